// File: rtl/amp_multi_vca.sv
// Multi-channel VCA: one shared multiplier, time-multiplexed one channel per clock, all outputs published together.
// Optional per-channel gain smoothing is enabled by defining AMP_GAIN_SMOOTH_EN.
module amp_multi_vca #(
  parameter int CHANNELS  = 4,
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 16,
  parameter int RAMP_STEP = 256
) (
  input  logic                         Sys_clk,
  input  logic                         Amp_rst_n,
  input  logic                         Amp_ce,
  input  logic [CHANNELS*GAIN_W-1:0]   Amplitude,
  input  logic [CHANNELS*DATA_W-1:0]   Oscillator,
  output logic [CHANNELS*DATA_W-1:0]   Amp_out,
  output logic                         Amp_valid,
  output logic                         Amp_busy
);

  localparam int CNT_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CHANNELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drain_q, drain_d;
  logic              issue, accept;

  logic        [GAIN_W-1:0] gain_q [CHANNELS];
  logic        [GAIN_W-1:0] gain_d [CHANNELS];
  logic signed [DATA_W-1:0] osc_q  [CHANNELS];

  logic signed [DATA_W-1:0] op_osc_q, op_osc_d;
  logic        [GAIN_W-1:0] op_gain_q, op_gain_d;
  logic                     s1_vld_q;
  logic        [CNT_W-1:0]  s1_ch_q;

  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic                     s2_vld_q;
  logic        [CNT_W-1:0]  s2_ch_q;

  logic signed [DATA_W-1:0] result;
  logic                     frame_done;
  logic signed [DATA_W-1:0] buf_q [CHANNELS];
  logic signed [DATA_W-1:0] buf_d [CHANNELS];
  logic signed [DATA_W-1:0] out_q [CHANNELS];
  logic                     valid_q;

  // A frame can be accepted in IDLE, or on the last DRAIN cycle so that a
  // continuously held Amp_ce restarts exactly on the Amp_valid edge.
  // NOTE: every combinational output is given a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    issue   = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (Amp_ce) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        issue = 1'b1;
        if (cnt_q == LAST_CH) begin
          cnt_d   = '0;
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!drain_q) begin
          drain_d = 1'b1;
        end else begin
          drain_d = 1'b0;
          if (Amp_ce) begin
            accept  = 1'b1;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [GAIN_W-1:0] tgt;
    assign tgt = Amplitude[k*GAIN_W +: GAIN_W];
`ifdef AMP_GAIN_SMOOTH_EN
    localparam int STEP_CLIP = (RAMP_STEP > (2**GAIN_W) - 1) ? (2**GAIN_W) - 1 : RAMP_STEP;
    localparam logic [GAIN_W-1:0] STEP = GAIN_W'(STEP_CLIP);
    // Move toward the target by at most STEP, landing exactly on it when close.
    always_comb begin
      if (tgt > gain_q[k]) begin
        gain_d[k] = (tgt - gain_q[k] > STEP) ? gain_q[k] + STEP : tgt;
      end else begin
        gain_d[k] = (gain_q[k] - tgt > STEP) ? gain_q[k] - STEP : tgt;
      end
    end
`else
    assign gain_d[k] = tgt;
`endif
    assign Amp_out[k*DATA_W +: DATA_W] = out_q[k];
  end

`ifndef AMP_GAIN_SMOOTH_EN
  logic unused_ramp;
  assign unused_ramp = ^RAMP_STEP;
`endif

  always_comb begin
    op_osc_d  = '0;
    op_gain_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        op_osc_d  = osc_q[k];
        op_gain_d = gain_q[k];
      end
    end
  end

  // Gain is unsigned, so it enters the signed multiply with a zero sign bit.
  assign prod_d = PROD_W'(op_osc_q) * PROD_W'($signed({1'b0, op_gain_q}));

  // Taking the bits above GAIN_W is an arithmetic shift (floor); gain < 1.0 keeps it in range.
  assign result     = prod_q[GAIN_W +: DATA_W];
  assign frame_done = s2_vld_q && (s2_ch_q == LAST_CH);

  logic unused_prod_bits;
  assign unused_prod_bits = ^{prod_q[PROD_W-1], prod_q[GAIN_W-1:0]};

  always_comb begin
    buf_d = buf_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (s2_vld_q && (s2_ch_q == CNT_W'(k))) buf_d[k] = result;
    end
  end

  // NOTE: the working buffer and latched inputs are reset element by element because a
  // mid-frame reset must leave no stale samples behind.
  always_ff @(posedge Sys_clk or negedge Amp_rst_n) begin
    if (!Amp_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      op_osc_q  <= '0;
      op_gain_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_ch_q   <= '0;
      prod_q    <= '0;
      s2_vld_q  <= 1'b0;
      s2_ch_q   <= '0;
      valid_q   <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        gain_q[k] <= '0;
        osc_q[k]  <= '0;
        buf_q[k]  <= '0;
        out_q[k]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      if (accept) begin
        for (int k = 0; k < CHANNELS; k++) begin
          gain_q[k] <= gain_d[k];
          osc_q[k]  <= Oscillator[k*DATA_W +: DATA_W];
        end
      end
      s1_vld_q <= issue;
      if (issue) begin
        op_osc_q  <= op_osc_d;
        op_gain_q <= op_gain_d;
        s1_ch_q   <= cnt_q;
      end
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        prod_q  <= prod_d;
        s2_ch_q <= s1_ch_q;
      end
      buf_q   <= buf_d;
      valid_q <= frame_done;
      // The last channel lands in the buffer on the same edge, so publish the updated copy.
      if (frame_done) out_q <= buf_d;
    end
  end

  assign Amp_valid = valid_q;
  assign Amp_busy  = (state_q != S_IDLE);

endmodule

// File: doc/amp_multi_vca.md
AMP_MULTI_VCA -- requirements
Module: amp_multi_vca

Interface
REQ-001 Parameter CHANNELS, 4, number of independent amplifier channels (1..16).
REQ-002 Parameter DATA_W, 16, signed oscillator/output sample width (8..24).
REQ-003 Parameter GAIN_W, 16, unsigned gain width, Q0.GAIN_W fraction (8..24).
REQ-004 Parameter RAMP_STEP, 256, maximum gain change per frame per channel (smoothing only).
REQ-005 Sys_clk  in  1  single system clock, all logic on rising edge.
REQ-006 Amp_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Amp_ce  in  1  frame start strobe, sampled on rising edge.
REQ-008 Amplitude  in  CHANNELS*GAIN_W  per-channel target gain, channel k at bits [k*GAIN_W +: GAIN_W].
REQ-009 Oscillator  in  CHANNELS*DATA_W  per-channel signed sample, channel k at bits [k*DATA_W +: DATA_W].
REQ-010 Amp_out  out  CHANNELS*DATA_W  per-channel signed amplified sample, same packing as Oscillator.
REQ-011 Amp_valid  out  1  one-cycle pulse, Amp_out updated this cycle.
REQ-012 Amp_busy  out  1  high while a frame is in progress.

Function
REQ-013 Block SHALL use one shared multiplier, time-multiplexed over channels, one channel per clock.
REQ-014 FSM states SHALL be IDLE, RUN, DRAIN; IDLE->RUN on Amp_ce=1, RUN->DRAIN after channel CHANNELS-1 issued, DRAIN->IDLE after 2 cycles.
REQ-015 On the edge sampling Amp_ce in IDLE, all Amplitude and Oscillator inputs SHALL be latched; later input changes SHALL not affect the frame.
REQ-016 Amp_ce while Amp_busy=1 SHALL be ignored (no queueing, no restart).
REQ-017 Channel index counter SHALL run 0..CHANNELS-1 in RUN and SHALL reset to 0 on entering IDLE.
REQ-018 Pipeline SHALL be: stage 1 operand select/register, stage 2 product register, stage 3 write to per-channel working buffer.
REQ-019 Product SHALL be full signed(DATA_W) x unsigned(GAIN_W) multiply, arithmetically shifted right by GAIN_W (floor toward minus infinity), truncated to DATA_W; no overflow is possible since gain < 1.0.
REQ-020 Amp_valid SHALL pulse exactly CHANNELS+2 rising edges after the edge sampling Amp_ce; all Amp_out channels SHALL update together on that edge from the working buffer.
REQ-021 Amp_out SHALL hold its value between Amp_valid pulses.
REQ-022 Amp_busy SHALL rise on the edge after Amp_ce is sampled and fall on the edge Amp_valid rises; a new Amp_ce SHALL be accepted on the edge where Amp_valid is high.
REQ-023 Gain 0 SHALL yield output 0; gain all-ones SHALL yield floor(x*(2^GAIN_W-1)/2^GAIN_W).

Reset
REQ-024 Amp_rst_n=0 SHALL asynchronously clear Amp_out, Amp_valid, Amp_busy, working buffer, pipeline, channel counter, smoothed gains to 0 and force IDLE.
REQ-025 Reset mid-frame SHALL abort the frame with no Amp_valid pulse; first frame after release behaves as from power-up.

Configuration
REQ-026 Macro AMP_GAIN_SMOOTH_EN defined: each channel SHALL keep a smoothed gain register, updated once per frame at latch time toward target by at most RAMP_STEP (clamped to target, never overshooting); the updated value SHALL be the gain used that frame.
REQ-027 Macro AMP_GAIN_SMOOTH_EN undefined: latched target gain SHALL be used directly; no smoothed-gain registers SHALL exist; RAMP_STEP is unused.

Verification
REQ-028 Defaults, smoothing off: ch0 gain 0x7FFF, osc 0x8000, Amp_ce one cycle -> Amp_valid 6 cycles later, ch0 Amp_out 0xC000.
REQ-029 All channels gain 0xFFFF, osc {0x7FFF, 0x0001, 0xFFFF, 0x0000} -> Amp_out {0x7FFE, 0x0000, 0xFFFF, 0x0000}.
REQ-030 Amp_ce held high continuously -> Amp_valid every 6 cycles, Amp_busy low only on no cycle after first, inputs changed mid-frame do not affect that frame.
REQ-031 Amp_rst_n low for 1 cycle at cycle 3 of a frame -> no Amp_valid, all outputs 0, next Amp_ce yields normal 6-cycle latency.
REQ-032 Smoothing on, RAMP_STEP 256: ch0 target jumps 0x0000->0x0400, osc 0x4000 -> successive frames use gain 0x100, 0x200, 0x300, 0x400, 0x400; outputs 0x0040, 0x0080, 0x00C0, 0x0100, 0x0100.
REQ-033 CHANNELS=1 and CHANNELS=16 builds: Amp_valid latency 3 and 18 cycles respectively, per-channel results match reference model.
